// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
// Shared definitions for the register-file write-side controller:
//   REG_PC      - architectural index of R15 (program counter)
//   NUM_REGS    - number of architectural registers
//   WB_DATA_W   - data width of a buffered write-back entry
//   wb_entry_t  - one buffered write-back (destination + value)
//   reg_onehot  - one-hot decode of a register index
package regfile_wb_pkg;

  localparam logic [3:0] REG_PC    = 4'd15;
  localparam int         NUM_REGS  = 16;
  localparam int         WB_DATA_W = 32;

  typedef struct packed {
    logic [3:0]           addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [3:0] a);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
  endfunction

endpackage

// File: rtl/regfile_write_port_wb_fifo.sv
// wb_fifo
// Parameterised synchronous FIFO holding write-back entries.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   push, push_data - enqueue request (ignored when full)
//   pop             - dequeue request (ignored when empty)
//   full, empty     - occupancy flags from the current count only
//   head            - oldest entry (zero when empty)
//   slots           - flat view of every storage slot, slot i at [i*W +: W]
//   slot_valid      - per-slot occupied flag
//   rd_ptr          - index of the oldest slot; slots age upward from here
module wb_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [W-1:0]               head,
  output logic [DEPTH*W-1:0]         slots,
  output logic [DEPTH-1:0]           slot_valid,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [W-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign full       = (count_r == CNT_DEPTH);
  assign empty      = (count_r == {CW{1'b0}});
  assign do_push_s  = push && !full;
  assign do_pop_s   = pop && !empty;
  assign slot_valid = valid_r;
  assign rd_ptr     = rd_ptr_r;

  // Head entry and flat storage view for the occupancy/bypass logic
  always_comb begin
    slots = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slots[i*W +: W] = mem_r[i];
    end
    if (empty) begin
      head = '0;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers and occupancy count; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      // A pop and a push never touch the same slot: push needs !full,
      // pop needs !empty, so wr_ptr == rd_ptr only when one is blocked.
      if (do_pop_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_ONE;
      end
      if (do_push_s) begin
        mem_r[wr_ptr_r]   <= push_data;
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r          <= wr_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// regfile_write_port
// Write-side controller for the 16-entry register file. Accepts write-back
// requests from the ALU (fixed priority) and the load path, buffers them in
// wb_fifo and drains one per cycle onto WE3/A3/WD3. Requests to R15 are
// consumed but dropped and flagged on the sticky err_r15.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   alu_valid/ready/addr/data        - ALU write-back request
//   mem_valid/ready/addr/data        - load-path write-back request
//   wb_stall                         - freeze draining
//   WE3, A3, WD3                     - register file write port
//   pending                          - bitmap of registers with buffered writes
//   err_r15                          - sticky: a request targeted R15
//   byp_addr, byp_hit, byp_data      - lookup of youngest buffered write
// Optional feature: define REGFILE_WRITE_PORT_BYPASS_EN to build the bypass
// lookup; otherwise byp_hit/byp_data are tied to zero.
import regfile_wb_pkg::*;

module regfile_write_port #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_valid,
  output logic         alu_ready,
  input  logic [3:0]   alu_addr,
  input  logic [N-1:0] alu_data,
  input  logic         mem_valid,
  output logic         mem_ready,
  input  logic [3:0]   mem_addr,
  input  logic [N-1:0] mem_data,
  input  logic         wb_stall,
  output logic         WE3,
  output logic [3:0]   A3,
  output logic [N-1:0] WD3,
  output logic [15:0]  pending,
  output logic         err_r15,
  input  logic [3:0]   byp_addr,
  output logic         byp_hit,
  output logic [N-1:0] byp_data
);

  localparam int W  = $bits(wb_entry_t);
  localparam int PW = $clog2(DEPTH);

  logic                full_s;
  logic                empty_s;
  wb_entry_t           head_s;
  logic [DEPTH*W-1:0]  slots_s;
  logic [DEPTH-1:0]    slot_valid_s;
  logic [PW-1:0]       rd_ptr_s;
  logic                alu_fire_s;
  logic                mem_fire_s;
  wb_entry_t           req_s;
  logic                push_s;
  logic                pop_s;
  logic                r15_hit_s;
  logic                err_r15_r;
  wb_entry_t           pend_e_s;
  logic [15:0]         pending_s;

  // Handshake: full looks at current occupancy only, ALU always wins
  assign alu_ready  = !rst && !full_s;
  assign mem_ready  = !rst && !full_s && !alu_valid;
  assign alu_fire_s = alu_valid && alu_ready;
  assign mem_fire_s = mem_valid && mem_ready;

  // Select the accepted request and split off R15 targets
  always_comb begin
    req_s = '0;
    if (alu_fire_s) begin
      req_s.addr = alu_addr;
      req_s.data = alu_data;
    end else if (mem_fire_s) begin
      req_s.addr = mem_addr;
      req_s.data = mem_data;
    end else begin
      req_s = '0;
    end
  end

  assign r15_hit_s = (alu_fire_s || mem_fire_s) && (req_s.addr == REG_PC);
  assign push_s    = (alu_fire_s || mem_fire_s) && (req_s.addr != REG_PC);
  assign pop_s     = !rst && !empty_s && !wb_stall;

  wb_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_data  (req_s),
    .pop        (pop_s),
    .full       (full_s),
    .empty      (empty_s),
    .head       (head_s),
    .slots      (slots_s),
    .slot_valid (slot_valid_s),
    .rd_ptr     (rd_ptr_s)
  );

  // Register file write port: head entry, enable only while draining
  assign WE3 = pop_s;
  always_comb begin
    if (rst || empty_s) begin
      A3  = 4'd0;
      WD3 = {N{1'b0}};
    end else begin
      A3  = head_s.addr;
      WD3 = head_s.data;
    end
  end

  // Sticky R15 error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r15_r <= 1'b0;
    end else if (r15_hit_s) begin
      err_r15_r <= 1'b1;
    end else begin
      err_r15_r <= err_r15_r;
    end
  end
  assign err_r15 = err_r15_r;

  // Pending bitmap: OR of one-hot destinations of all occupied slots
  always_comb begin
    pending_s = 16'h0000;
    pend_e_s  = '0;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pend_e_s = slots_s[i*W +: W];
        if (slot_valid_s[i]) begin
          pending_s = pending_s | reg_onehot(pend_e_s.addr);
        end else begin
          pending_s = pending_s;
        end
      end
    end else begin
      pending_s = 16'h0000;
    end
    pending_s[REG_PC] = 1'b0;
  end
  assign pending = pending_s;

`ifdef REGFILE_WRITE_PORT_BYPASS_EN
  logic [PW-1:0] byp_idx_s;
  wb_entry_t     byp_e_s;

  // Walk slots oldest to youngest so the last match is the youngest entry
  always_comb begin
    byp_hit   = 1'b0;
    byp_data  = {N{1'b0}};
    byp_idx_s = '0;
    byp_e_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx_s = rd_ptr_s + PW'(i);
      byp_e_s   = slots_s[int'(byp_idx_s)*W +: W];
      if (slot_valid_s[byp_idx_s] && (byp_e_s.addr == byp_addr) &&
          (byp_addr != REG_PC)) begin
        byp_hit  = 1'b1;
        byp_data = byp_e_s.data;
      end else begin
        byp_hit  = byp_hit;
      end
    end
  end
`else
  logic byp_unused_s;
  assign byp_unused_s = ^{byp_addr, rd_ptr_s};
  assign byp_hit      = 1'b0;
  assign byp_data     = {N{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
// tb_regfile_write_port
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared against a queue-based model of the write-back buffer.
module tb_regfile_write_port;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         alu_valid, alu_ready;
  logic [3:0]   alu_addr;
  logic [N-1:0] alu_data;
  logic         mem_valid, mem_ready;
  logic [3:0]   mem_addr;
  logic [N-1:0] mem_data;
  logic         wb_stall;
  logic         WE3;
  logic [3:0]   A3;
  logic [N-1:0] WD3;
  logic [15:0]  pending;
  logic         err_r15;
  logic [3:0]   byp_addr;
  logic         byp_hit;
  logic [N-1:0] byp_data;

  regfile_write_port #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_stall(wb_stall), .WE3(WE3), .A3(A3), .WD3(WD3),
    .pending(pending), .err_r15(err_r15),
    .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   err_m;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [3:0] a, input logic [31:0] d);
    ent_t e;
    if (a == 4'd15) begin
      err_m = 1'b1;
    end else begin
      e.a = a;
      e.d = d;
      q.push_back(e);
    end
  endtask

  // Apply one cycle of inputs, compare outputs to the model, advance the model
  task automatic step(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                      input logic mv, input logic [3:0] ma, input logic [31:0] md,
                      input logic st, input logic r, input logic [3:0] ba);
    bit          full_m, we_m, hit_m;
    logic [15:0] pend_m;
    logic [31:0] bd_m;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    wb_stall = st; rst = r; byp_addr = ba;
    #1;
    full_m = (q.size() >= DEPTH);
    we_m   = !r && (q.size() > 0) && !st;
    check_eq("alu_ready", alu_ready, !r && !full_m);
    check_eq("mem_ready", mem_ready, !r && !full_m && !av);
    check_eq("WE3", WE3, we_m);
    check_eq("no_pc_write", WE3 && (A3 == 4'd15), 1'b0);
    check_eq("err_r15", err_r15, err_m);
    if (!r) begin
      if (q.size() > 0) begin
        check_eq("A3", A3, q[0].a);
        check_eq("WD3", WD3, q[0].d);
      end else begin
        check_eq("A3_empty", A3, 4'd0);
        check_eq("WD3_empty", WD3, 32'd0);
      end
      pend_m = 16'h0000;
      foreach (q[i]) pend_m[q[i].a] = 1'b1;
      check_eq("pending", pending, pend_m);
    end
    hit_m = 1'b0;
    bd_m  = 32'd0;
`ifdef REGFILE_WRITE_PORT_BYPASS_EN
    foreach (q[i]) begin
      if (q[i].a == ba && ba != 4'd15) begin
        hit_m = 1'b1;
        bd_m  = q[i].d;
      end
    end
`endif
    check_eq("byp_hit", byp_hit, hit_m);
    check_eq("byp_data", byp_data, bd_m);
    // model update for the coming rising edge
    if (r) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      if (we_m) void'(q.pop_front());
      if (av && !full_m) accept(aa, ad);
      else if (mv && !full_m && !av) accept(ma, md);
    end
  endtask

  task automatic idle(input logic st);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, st, 1'b0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0;
    alu_addr = 4'd0; alu_data = 32'd0; mem_addr = 4'd0; mem_data = 32'd0; byp_addr = 4'd0;
    err_m = 1'b0;

    // Reset and reset-state values
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 4'd0);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 4'd0);
    check_eq("rst_we3", WE3, 1'b0);
    check_eq("rst_ready", alu_ready, 1'b0);
    idle(1'b0);
    check_eq("post_rst_A3", A3, 4'd0);
    check_eq("post_rst_WD3", WD3, 32'd0);
    check_eq("post_rst_pending", pending, 16'h0000);
    check_eq("post_rst_err", err_r15, 1'b0);
    check_eq("post_rst_byp", byp_hit, 1'b0);

    // Single ALU write r3 = 0xAA, visible next cycle
    step(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    check_eq("t1_pend_t", pending, 16'h0000);
    idle(1'b0);
    check_eq("t1_we3", WE3, 1'b1);
    check_eq("t1_a3", A3, 4'd3);
    check_eq("t1_wd3", WD3, 32'h0000_00AA);
    check_eq("t1_pend", pending, 16'h0008);
    idle(1'b0);
    check_eq("t1_pend_after", pending, 16'h0000);

    // Simultaneous requests: ALU first, then mem
    step(1'b1, 4'd1, 32'd5, 1'b1, 4'd2, 32'd6, 1'b0, 1'b0, 4'd0);
    check_eq("t2_mem_ready", mem_ready, 1'b0);
    step(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'd6, 1'b0, 1'b0, 4'd0);
    check_eq("t2_mem_ready2", mem_ready, 1'b1);
    check_eq("t2_first", A3, 4'd1);
    idle(1'b0);
    check_eq("t2_second", A3, 4'd2);
    check_eq("t2_wd3", WD3, 32'd6);

    // Stall and fill: r4..r7
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'(4 + i), 32'(100 + i), 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 4'd8, 32'd200, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0);
    check_eq("t3_full_ready", alu_ready, 1'b0);
    check_eq("t3_we3", WE3, 1'b0);
    check_eq("t3_pending", pending, 16'h00F0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check_eq("t3_drain_we", WE3, 1'b1);
      check_eq("t3_drain_a3", A3, 4'(4 + i));
    end

    // R15 write: consumed, flagged, never written
    step(1'b1, 4'd15, 32'h1234, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    check_eq("t4_ready", alu_ready, 1'b1);
    idle(1'b0);
    check_eq("t4_we3", WE3, 1'b0);
    check_eq("t4_err", err_r15, 1'b1);
    idle(1'b0);
    check_eq("t4_err_hold", err_r15, 1'b1);

    // Reset with 3 buffered entries under stall
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'(1 + i), 32'(i), 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 4'd0);
    check_eq("t5_rst_we3", WE3, 1'b0);
    idle(1'b0);
    check_eq("t5_we3", WE3, 1'b0);
    check_eq("t5_pending", pending, 16'h0000);
    check_eq("t5_err", err_r15, 1'b0);

    // Bypass: two writes to r9 under stall
    step(1'b1, 4'd9, 32'h11, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd9);
    step(1'b1, 4'd9, 32'h22, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd9);
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd9);
`ifdef REGFILE_WRITE_PORT_BYPASS_EN
    check_eq("t6_hit", byp_hit, 1'b1);
    check_eq("t6_data", byp_data, 32'h22);
`else
    check_eq("t6_hit", byp_hit, 1'b0);
    check_eq("t6_data", byp_data, 32'h0);
`endif
    idle(1'b0);
    idle(1'b0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0),
           4'($urandom_range(0, 15)));
    end
    for (int c = 0; c < 6; c++) idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_write_port.md
# regfile_write_port

Write-side controller for the 16-entry register file: accepts write-back requests from the ALU and the load path, buffers them in a small FIFO, and drains them one per cycle onto the register file's write port (WE3/A3/WD3). It sits between the execute/memory stages and the register file. It guarantees that R15 (PC) is never written through the general port, and it publishes a pending-write bitmap for hazard detection.

## Interface
- N, 32, data width; must match the register file.
- DEPTH, 4, FIFO entries; power of two, 2..16.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU write request present.
- alu_ready  out  1  request accepted this cycle.
- alu_addr  in  4  destination register.
- alu_data  in  N  write value.
- mem_valid / mem_ready / mem_addr / mem_data  in/out/in/in  1/1/4/N  load-path request; same meaning as the ALU port.
- wb_stall  in  1  freeze draining; the register file must not be written.
- WE3  out  1  register file write enable.
- A3  out  4  register file write address.
- WD3  out  N  register file write data.
- pending  out  16  bit i set while any buffered entry targets register i.
- err_r15  out  1  sticky; set when a request targets register 15.
- byp_addr  in  4  bypass lookup address.
- byp_hit  out  1  bypass match found.
- byp_data  out  N  bypass data.

## Operation
- At most one enqueue per cycle. ALU has fixed priority: mem_ready = 0 whenever alu_valid = 1.
- alu_ready = !full. mem_ready = !full && !alu_valid. A transfer occurs when valid && ready.
- Any accepted request with addr = 15 is consumed (ready handshake completes) but not enqueued, and err_r15 is set. err_r15 clears only on rst.
- Drain: when the FIFO is not empty and wb_stall = 0, drive the head entry: WE3 = 1, A3 = head.addr, WD3 = head.data. The entry pops on the same edge.
- When the FIFO is empty or wb_stall = 1: WE3 = 0, and A3/WD3 hold the head entry (or 0 when empty).
- full uses the current occupancy only. A drain in the same cycle does not free a slot for that cycle's enqueue. Simultaneous enqueue and drain leaves the count unchanged.
- pending: the OR over valid entries of their one-hot addr, computed combinationally from FIFO storage. pending[15] is always 0.
- Multiple entries may target the same register. They drain in order, and the last write wins in the register file.
- Pointers wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits wide.

## Timing
- Reset values: FIFO empty, WE3 = 0, A3 = 0, WD3 = 0, pending = 0, err_r15 = 0, byp_hit = 0, byp_data = 0.
- alu_ready and mem_ready are 0 while rst = 1.
- Latency: a request accepted in cycle t appears on WE3/A3/WD3 in cycle t+1 at the earliest, assuming an empty FIFO and no stall.
- Throughput: one write per cycle sustained.
- Reset mid-operation: all buffered entries are discarded without being written. WE3 = 0 during the reset cycle.
- wb_stall asserted with a full FIFO: both ready outputs stay 0, and nothing is lost.

## Configuration
- Macro: REGFILE_WRITE_PORT_BYPASS_EN.
- With the macro defined: byp_hit = 1 when any valid entry has addr = byp_addr. byp_data is the data of the youngest such entry. Both are combinational. byp_addr = 15 never hits.
- Without the macro: byp_hit = 0 and byp_data = 0 constant. The ports remain present, and no comparator logic is generated.

## Structure
- Package regfile_wb_pkg holds:
  - REG_PC = 4'd15
  - NUM_REGS = 16
  - typedef struct wb_entry_t { logic [3:0] addr; logic [N-1:0] data; }, with N passed as a parameterised width or as a fixed 32 in the package.
- One sub-module, wb_fifo: a parameterised synchronous FIFO with push, pop, full, empty and head outputs, plus a flat storage/valid view used for pending and bypass.

## Test plan
- Reset, then ALU write r3 = 0x0000_00AA at t. Expect WE3 = 1, A3 = 3, WD3 = 0xAA at t+1, and pending[3] = 1 only during cycle t+1.
- alu_valid and mem_valid high together (r1 = 5, r2 = 6). Expect the ALU accepted first and mem_ready = 0. The mem write is accepted in the next cycle, and writes drain in the order r1 then r2.
- wb_stall = 1 and 4 ALU writes (r4..r7). Expect the FIFO full, alu_ready = 0 on the 5th, WE3 = 0, and pending = 0x00F0. Release the stall: 4 consecutive writes, in order.
- Write to r15 = 0x1234. Expect the handshake completes, WE3 is never asserted for A3 = 15, and err_r15 = 1 and holds until rst.
- Stall with 3 entries buffered, then assert rst for one cycle. Expect no WE3 pulse, pending = 0, and the FIFO empty afterwards.
- With the macro defined: buffer r9 = 0x11 then r9 = 0x22 under stall, with byp_addr = 9. Expect byp_hit = 1 and byp_data = 0x22. Without the macro, byp_hit = 0.
